// File: rtl/sha_pkg.sv
// Shared constants for the SHA-2 message-schedule stream: sigma rotate/shift
// amounts for both word widths, window geometry, taps and FSM encodings.
package sha_pkg;

  localparam int DEPTH = 16;

  // Window positions of the recurrence operands; mem[15] is W[t-1].
  localparam int TAP_W16 = 0;
  localparam int TAP_W15 = 1;
  localparam int TAP_W7  = 9;
  localparam int TAP_W2  = 14;

  localparam int S256_S0_R1 = 7;
  localparam int S256_S0_R2 = 18;
  localparam int S256_S0_SH = 3;
  localparam int S256_S1_R1 = 17;
  localparam int S256_S1_R2 = 19;
  localparam int S256_S1_SH = 10;

  localparam int S512_S0_R1 = 1;
  localparam int S512_S0_R2 = 8;
  localparam int S512_S0_SH = 7;
  localparam int S512_S1_R1 = 19;
  localparam int S512_S1_R2 = 61;
  localparam int S512_S1_SH = 6;

  localparam logic [0:0] LOAD   = 1'b0;
  localparam logic [0:0] EXPAND = 1'b1;

endpackage

// File: rtl/msg_sigma.sv
// Combinational SHA-2 small sigmas; width selects the SHA-256 or SHA-512 set.
module msg_sigma
  import sha_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] x0,
  input  logic [WORD_W-1:0] x1,
  output logic [WORD_W-1:0] s0,
  output logic [WORD_W-1:0] s1
);

  localparam bit WIDE  = (WORD_W == 64);
  localparam int S0_R1 = WIDE ? S512_S0_R1 : S256_S0_R1;
  localparam int S0_R2 = WIDE ? S512_S0_R2 : S256_S0_R2;
  localparam int S0_SH = WIDE ? S512_S0_SH : S256_S0_SH;
  localparam int S1_R1 = WIDE ? S512_S1_R1 : S256_S1_R1;
  localparam int S1_R2 = WIDE ? S512_S1_R2 : S256_S1_R2;
  localparam int S1_SH = WIDE ? S512_S1_SH : S256_S1_SH;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  assign s0 = rotr(x0, S0_R1) ^ rotr(x0, S0_R2) ^ (x0 >> S0_SH);
  assign s1 = rotr(x1, S1_R1) ^ rotr(x1, S1_R2) ^ (x1 >> S1_SH);

endmodule

// File: rtl/msg_schedule_stream.sv
// SHA-2 message-schedule generator: takes 16 block words over a valid/ready
// stream and emits W[0..ROUNDS-1] with round index through one output register.
module msg_schedule_stream
  import sha_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W-1:0]         in_word,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W-1:0]         out_word,
  output logic [$clog2(ROUNDS)-1:0] out_idx,
  output logic                      out_last,
  output logic                      busy
);

  localparam int IDX_W = $clog2(ROUNDS);
  localparam logic [IDX_W-1:0] LOAD_END = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  generate
    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
      $error("msg_schedule_stream: WORD_W must be 32 or 64");
    end
    if (ROUNDS < 17) begin : g_bad_rounds
      $error("msg_schedule_stream: ROUNDS must be at least 17");
    end
  endgenerate

  logic [0:0]                   state;
  logic [IDX_W-1:0]             cnt;
  logic [DEPTH-1:0][WORD_W-1:0] mem;
  logic [WORD_W-1:0]            s0, s1, w_exp, new_word;
  logic                         is_load, slot_free, accept, produce;

  msg_sigma #(.WORD_W(WORD_W)) u_sigma (
    .x0 (mem[TAP_W15]),
    .x1 (mem[TAP_W2]),
    .s0 (s0),
    .s1 (s1)
  );

  // Modulo-2^WORD_W sum; carries out of the top bit are simply dropped.
  assign w_exp     = s1 + mem[TAP_W7] + s0 + mem[TAP_W16];

  assign is_load   = (state == LOAD);
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = is_load && slot_free && !rst;
  assign accept    = in_valid && in_ready;
  assign produce   = is_load ? accept : slot_free;
  assign new_word  = is_load ? in_word : w_exp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= '0;
      mem       <= '0;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (produce) begin
        mem       <= {new_word, mem[DEPTH-1:1]};
        out_valid <= 1'b1;
        out_word  <= new_word;
        out_idx   <= cnt;
        out_last  <= !is_load && (cnt == LAST_IDX);
        if (is_load) begin
          if (cnt == LOAD_END) state <= EXPAND;
          cnt <= cnt + 1'b1;
        end else if (cnt == LAST_IDX) begin
          state <= LOAD;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // A word accepted on the final handshake keeps the block busy.
      if (accept) busy <= 1'b1;
      else if (out_valid && out_ready && out_last) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_msg_schedule_stream.sv
// Scoreboard bench for msg_schedule_stream: SHA-256 and SHA-512 instances,
// directed blocks, backpressure, back-to-back blocks and mid-block reset.
module tb_msg_schedule_stream;

  typedef struct {
    logic [63:0] word;
    int          idx;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid32 = 1'b0, in_ready32, out_valid32, out_last32, busy32;
  logic [31:0] in_word32 = '0, out_word32;
  logic [5:0]  out_idx32;
  logic        ready_fix32 = 1'b1, rnd_bit = 1'b1, rnd_mode = 1'b0, out_ready32;
  assign out_ready32 = rnd_mode ? rnd_bit : ready_fix32;

  logic        in_valid64 = 1'b0, in_ready64, out_valid64, out_last64, busy64;
  logic        out_ready64 = 1'b1;
  logic [63:0] in_word64 = '0, out_word64;
  logic [6:0]  out_idx64;

  msg_schedule_stream #(.WORD_W(32), .ROUNDS(64)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .in_word(in_word32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_word(out_word32),
    .out_idx(out_idx32), .out_last(out_last32), .busy(busy32));

  msg_schedule_stream #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64), .in_word(in_word64),
    .out_valid(out_valid64), .out_ready(out_ready64), .out_word(out_word64),
    .out_idx(out_idx64), .out_last(out_last64), .busy(busy64));

  int checks = 0, passes = 0, cyc = 0;
  exp_t q32[$], q64[$];
  logic [31:0] blk32 [16];
  logic [63:0] blk64 [16];
  logic [31:0] seen32 [64];
  logic [63:0] seen64 [80];
  int in_hs32 = 0, first32 = 0, last32 = 0, first64 = 0, last64 = 0;
  bit first_set32 = 0, first_set64 = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [31:0] r32(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction
  function automatic logic [63:0] r64(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  task automatic push_exp32();
    logic [31:0] w [64];
    exp_t e;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = blk32[t];
      else w[t] = (r32(w[t-2], 17) ^ r32(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                + (r32(w[t-15], 7) ^ r32(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      e.word = {32'h0, w[t]}; e.idx = t; e.last = (t == 63);
      q32.push_back(e);
    end
  endtask

  task automatic push_exp64();
    logic [63:0] w [80];
    exp_t e;
    for (int t = 0; t < 80; t++) begin
      if (t < 16) w[t] = blk64[t];
      else w[t] = (r64(w[t-2], 19) ^ r64(w[t-2], 61) ^ (w[t-2] >> 6)) + w[t-7]
                + (r64(w[t-15], 1) ^ r64(w[t-15], 8) ^ (w[t-15] >> 7)) + w[t-16];
      e.word = w[t]; e.idx = t; e.last = (t == 79);
      q64.push_back(e);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // Output monitors: every presented handshake pops the next expected word.
  logic        stall_prev = 1'b0;
  logic [31:0] prev_word;
  logic [5:0]  prev_idx;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid32 === 1'b1 && out_ready32 === 1'b1) begin
      if (q32.size() == 0) check("out32_unexpected", 64'(out_idx32), 64'hffff);
      else begin
        e = q32.pop_front();
        check("word32", 64'(out_word32), e.word);
        check("idx32", 64'(out_idx32), 64'(e.idx));
        check("last32", 64'(out_last32), 64'(e.last));
      end
      seen32[out_idx32] = out_word32;
      if (!first_set32) begin first32 = cyc; first_set32 = 1; end
      last32 = cyc;
    end
    if (stall_prev) check("stall_hold32", {out_valid32, out_idx32, out_word32}, {1'b1, prev_idx, prev_word});
    stall_prev = (out_valid32 === 1'b1) && (out_ready32 === 1'b0);
    prev_word  = out_word32;
    prev_idx   = out_idx32;
    if (in_valid32 && in_ready32 === 1'b1) in_hs32++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (out_valid64 === 1'b1 && out_ready64) begin
      if (q64.size() == 0) check("out64_unexpected", 64'(out_idx64), 64'hffff);
      else begin
        e = q64.pop_front();
        check("word64", out_word64, e.word);
        check("idx64", 64'(out_idx64), 64'(e.idx));
        check("last64", 64'(out_last64), 64'(e.last));
      end
      seen64[out_idx64] = out_word64;
      if (!first_set64) begin first64 = cyc; first_set64 = 1; end
      last64 = cyc;
    end
  end

  task automatic send32();
    for (int i = 0; i < 16; i++) begin
      int t = 0;
      in_valid32 = 1'b1;
      in_word32  = blk32[i];
      do begin @(negedge clk); t++; end while (in_ready32 !== 1'b1 && t < 2000);
      if (t >= 2000) begin check("send32_timeout", 64'(i), 64'hffff); break; end
      @(posedge clk); #1;
    end
    in_valid32 = 1'b0;
  endtask

  task automatic send64();
    for (int i = 0; i < 16; i++) begin
      int t = 0;
      in_valid64 = 1'b1;
      in_word64  = blk64[i];
      do begin @(negedge clk); t++; end while (in_ready64 !== 1'b1 && t < 2000);
      if (t >= 2000) begin check("send64_timeout", 64'(i), 64'hffff); break; end
      @(posedge clk); #1;
    end
    in_valid64 = 1'b0;
  endtask

  task automatic drain32();
    int t = 0;
    while (q32.size() != 0 && t < 3000) begin @(posedge clk); #1; t++; end
    if (q32.size() != 0) check("drain32_timeout", 64'(q32.size()), 64'h0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic abc32();
    for (int i = 0; i < 16; i++) blk32[i] = 32'h0;
    blk32[0] = 32'h61626380; blk32[15] = 32'h00000018;
  endtask

  initial begin
    int bad;
    int t;
    in_valid32 = 1'b1;
    in_valid64 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid32), 64'h0);
    check("rst_out_word", 64'(out_word32), 64'h0);
    check("rst_out_idx", 64'(out_idx32), 64'h0);
    check("rst_out_last", 64'(out_last32), 64'h0);
    check("rst_busy", 64'(busy32), 64'h0);
    check("rst_in_ready", 64'(in_ready32), 64'h0);
    check("rst_in_ready64", 64'(in_ready64), 64'h0);
    in_valid32 = 1'b0; in_valid64 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // abc block, full-rate consumer
    abc32(); push_exp32();
    in_hs32 = 0; first_set32 = 0;
    send32(); drain32();
    check("abc_w16", 64'(seen32[16]), 64'h61626380);
    check("abc_w17", 64'(seen32[17]), 64'h000F0000);
    check("abc_span", 64'(last32 - first32), 64'd63);
    check("abc_in_hs", 64'(in_hs32), 64'd16);
    check("idle_busy", 64'(busy32), 64'h0);

    // same block under random backpressure
    rnd_mode = 1'b1;
    push_exp32(); send32(); drain32();
    rnd_mode = 1'b0;
    check("rnd_w16", 64'(seen32[16]), 64'h61626380);

    // two blocks back-to-back, no bubble
    in_hs32 = 0; first_set32 = 0;
    push_exp32(); send32();
    for (int i = 0; i < 16; i++) blk32[i] = (32'h01010101 * (i + 1)) ^ 32'h5a5a0000;
    push_exp32(); send32();
    bad = 0;
    while (q32.size() != 0 && bad < 3000) begin
      @(posedge clk); #1;
      if (q32.size() != 0 && busy32 !== 1'b1) bad = bad + 1000;
      else bad++;
    end
    check("b2b_busy_high", 64'(bad >= 1000), 64'h0);
    check("b2b_span", 64'(last32 - first32), 64'd127);
    check("b2b_in_hs", 64'(in_hs32), 64'd32);
    drain32();

    // in_valid held through EXPAND
    abc32(); push_exp32();
    in_hs32 = 0;
    send32();
    in_valid32 = 1'b1; in_word32 = 32'hdeadbeef;
    repeat (40) @(posedge clk);
    #1 in_valid32 = 1'b0;
    drain32();
    check("hold_in_hs", 64'(in_hs32), 64'd16);

    // reset in the middle of EXPAND
    push_exp32(); send32();
    t = 0;
    while (!(out_valid32 === 1'b1 && out_idx32 == 6'd30) && t < 200) begin @(posedge clk); #1; t++; end
    check("mid_reached_30", 64'(out_idx32), 64'd30);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q32.delete();
    check("mid_rst_valid", 64'(out_valid32), 64'h0);
    check("mid_rst_idx", 64'(out_idx32), 64'h0);
    check("mid_rst_busy", 64'(busy32), 64'h0);
    repeat (5) @(posedge clk);
    #1 check("mid_rst_quiet", 64'(out_valid32), 64'h0);
    seen32[16] = 32'h0;
    push_exp32(); send32(); drain32();
    check("mid_w16", 64'(seen32[16]), 64'h61626380);

    // SHA-512 abc block
    for (int i = 0; i < 16; i++) blk64[i] = 64'h0;
    blk64[0] = 64'h6162638000000000; blk64[15] = 64'h18;
    push_exp64(); send64();
    t = 0;
    while (q64.size() != 0 && t < 3000) begin @(posedge clk); #1; t++; end
    if (q64.size() != 0) check("drain64_timeout", 64'(q64.size()), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    check("w64_w16", seen64[16], 64'h6162638000000000);
    check("w64_w17", seen64[17], 64'h00030000000000C0);
    check("w64_span", 64'(last64 - first64), 64'd79);
    check("w64_busy_end", 64'(busy64), 64'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/msg_schedule_stream.md
Name: msg_schedule_stream

Overview:
Parametrised SHA-2 message-schedule generator, the successor to the fixed 32-bit expansion shift register.
- Accepts the 16 words of one padded message block over a valid/ready input stream.
- Emits the full schedule W[0..ROUNDS-1] in order over a valid/ready output stream, tagged with the round index.
- Supports SHA-256 (32-bit) and SHA-512 (64-bit) words, output backpressure, and back-to-back blocks.
- Sits between the block padder and the compression round engine, and feeds the KDF PRF core.

Parameters:
WORD_W, 32, word width: 32 selects SHA-256 sigmas, 64 selects SHA-512 sigmas; any other value is an elaboration error.
ROUNDS, 64, schedule length: 64 for SHA-256, 80 for SHA-512; values below 17 are an elaboration error.

Ports:
clk  in  1  single clock, all logic rising-edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  in_word is valid.
in_ready  out  1  block accepts in_word this cycle.
in_word  in  WORD_W  message word, big-endian word order, W0 first.
out_valid  out  1  out_word/out_idx/out_last are valid.
out_ready  in  1  consumer accepts the output this cycle.
out_word  out  WORD_W  schedule word W[out_idx].
out_idx  out  $clog2(ROUNDS)  round index t.
out_last  out  1  high with t = ROUNDS-1.
busy  out  1  high from the first accepted word until the last output handshake.

Behaviour:
- Reset (rst=1 at a clock edge): out_valid=0, out_word=0, out_idx=0, out_last=0, busy=0, state=LOAD, cnt=0, window cleared. in_ready=0 while rst is high. Reset mid-block discards all partial state; no output follows until new input arrives.
- Output stage is one register. slot_free = !out_valid || out_ready.
- Window: 16 x WORD_W shift register. mem[15] holds W[t-1] and mem[0] holds W[t-16]. Each produce shifts all entries down by one and writes the new word into mem[15].
- Taps: W[t-16]=mem[0], W[t-15]=mem[1], W[t-7]=mem[9], W[t-2]=mem[14].
- Expansion: W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], modulo 2^WORD_W. Carries are discarded.
- Sigmas for WORD_W=32:
  - s0 = ROTR7 ^ ROTR18 ^ SHR3
  - s1 = ROTR17 ^ ROTR19 ^ SHR10
- Sigmas for WORD_W=64:
  - s0 = ROTR1 ^ ROTR8 ^ SHR7
  - s1 = ROTR19 ^ ROTR61 ^ SHR6
- State LOAD (cnt 0..15):
  - in_ready = slot_free && !rst.
  - produce = in_valid && in_ready.
  - On produce: out_word <= in_word, out_idx <= cnt, window shifts, cnt++.
  - After the produce with cnt=15, go to EXPAND with cnt=16.
- State EXPAND (cnt 16..ROUNDS-1):
  - in_ready=0.
  - produce = slot_free.
  - On produce: out_word <= computed W[cnt], window shifts, cnt++.
  - After the produce with cnt=ROUNDS-1, set out_last=1, return to LOAD with cnt=0.
- Stall: when !slot_free, the output registers, window, cnt and state all hold.
- Latency and throughput: out_valid rises the cycle after the accepting edge. With out_ready held high the block sustains 1 word/cycle, i.e. ROUNDS cycles per block.
- Back-to-back blocks: word 0 of the next block may be accepted in the cycle the W[ROUNDS-1] handshake occurs. No bubble is required.
- out_last is cleared on the next produce.
- busy falls on the out_last handshake, unless a new word is accepted in the same cycle.
- in_valid asserted during EXPAND is ignored; the upstream stream simply stalls.

Decomposition:
- Shared package sha_pkg holds:
  - rotate/shift amount constants for both widths;
  - the state enum {LOAD, EXPAND};
  - the DEPTH=16 window localparam;
  - tap index constants 0, 1, 9, 14.
- One sub-module, msg_sigma (parameter WORD_W): purely combinational sigma0 and sigma1, instantiated once.
- The 4-input modular adder stays inline.

Test Plan:
- SHA-256 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready=1 → 64 outputs on consecutive cycles, idx 0..63. W16=0x61626380, W17=0x000F0000; W18..W63 match the golden model; out_last only at idx 63.
- Same block with out_ready toggling in a random pattern → identical word sequence. out_word is stable while out_valid && !out_ready, and no index is skipped or repeated.
- Two blocks streamed back-to-back → second block's idx 0 appears the cycle after first block's idx 63 handshake; busy stays high throughout.
- rst pulsed at cnt=30 of EXPAND → next cycle out_valid=0, idx resets. A fresh "abc" block then yields the correct W16=0x61626380.
- WORD_W=64, ROUNDS=80, SHA-512 "abc" block (W0=0x6162638000000000, W15=0x18) → W16=0x6162638000000000, W17=0x00030000000000C0, 80 outputs, out_last at idx 79.
- in_valid held high during EXPAND → in_ready=0 throughout. Exactly 16 input handshakes occur per block.
